// File: rtl/mem_access.sv
// mem_access: load/store unit with 3-state IDLE/ACCESS/DONE sequencing, RAM/IO routing and lane handling
module mem_access #(
   parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
   parameter int          RAM_AW  = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3,
   input  logic [31:0]       ALUResult,
   input  logic [31:0]       ReadData2,
   input  logic [31:0]       mem_rdata,
   input  logic [31:0]       io_rdata,
   output logic [RAM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_we,
   output logic [31:0]       io_addr,
   output logic [31:0]       io_wdata,
   output logic              io_rd,
   output logic              io_wr,
   output logic              stall,
   output logic [31:0]       LoadData,
   output logic              load_valid,
   output logic              fault
);
   localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
   logic [1:0]  state, nxt;
   logic [31:0] a, d, ld, wd, rdata, sh, ext;
   logic [2:0]  f;
   logic        wr, io, rd_ok, wr_ok, mis, illegal, fault_cond, accept, idle, acc, done;
   logic [4:0]  sa;
   logic [3:0]  mask;
   assign rd_ok      = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   assign wr_ok      = ~funct3[2] & (funct3[1:0] != 2'b11);
   assign mis        = (funct3[1:0] == 2'b01 & ALUResult[0]) | (funct3[1:0] == 2'b10 & |ALUResult[1:0]);
   assign illegal    = (MemRead & MemWrite) | (MemRead & ~rd_ok) | (MemWrite & ~wr_ok) | mis;
   assign fault_cond = req_valid & (MemRead | MemWrite) & illegal;
   assign idle       = state == IDLE;
   assign acc        = state == ACCESS & ~rst;
   assign done       = state == DONE & ~rst;
   assign accept     = idle & req_valid & (MemRead ^ MemWrite) & ~illegal;
   assign fault      = idle & fault_cond & ~rst;
   assign stall      = ~rst & state != DONE & req_valid & (MemRead | MemWrite) & ~fault_cond;
   // alignment is guaranteed at accept, so one byte-granular shift serves b/h/w
   assign sa         = {a[1:0], 3'b000};
   assign mask       = f[1] ? 4'hF : f[0] ? (a[1] ? 4'hC : 4'h3) : 4'b0001 << a[1:0];
   assign wd         = rst ? 32'd0 : d << sa;
   assign mem_wdata  = wd;
   assign io_wdata   = wd;
   assign mem_we     = (acc & wr & ~io) ? mask : 4'd0;
   assign io_wr      = acc & wr & io;
   assign io_rd      = acc & ~wr & io;
   assign mem_addr   = (~idle & ~rst) ? a[RAM_AW+1:2] : '0;
   assign io_addr    = (~idle & ~rst) ? a : 32'd0;
   assign rdata      = io ? io_rdata : mem_rdata;
   assign sh         = rdata >> sa;
   assign ext        = f[1] ? sh : f[0] ? {{16{~f[2] & sh[15]}}, sh[15:0]} : {{24{~f[2] & sh[7]}}, sh[7:0]};
   assign load_valid = done & ~wr;
   assign LoadData   = rst ? 32'd0 : load_valid ? ext : ld;
   assign nxt        = idle ? (accept ? ACCESS : IDLE) : state == ACCESS ? DONE : IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a     <= '0;
         d     <= '0;
         f     <= '0;
         wr    <= 1'b0;
         io    <= 1'b0;
         ld    <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            a  <= ALUResult;
            d  <= ReadData2;
            f  <= funct3;
            wr <= MemWrite;
            io <= ALUResult >= IO_BASE;
         end
         if (load_valid) ld <= ext;
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access (loads queued at issue, popped on load_valid)
module tb_mem_access;
   logic        clk, rst, req_valid, MemRead, MemWrite;
   logic [2:0]  funct3;
   logic [31:0] ALUResult, ReadData2, mem_rdata, io_rdata;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata, io_addr, io_wdata, LoadData;
   logic [3:0]  mem_we;
   logic        io_rd, io_wr, stall, load_valid, fault;
   int          total = 0, bad = 0;
   logic [31:0] sb[$];

   mem_access dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .MemRead(MemRead), .MemWrite(MemWrite),
      .funct3(funct3), .ALUResult(ALUResult), .ReadData2(ReadData2), .mem_rdata(mem_rdata),
      .io_rdata(io_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_rd(io_rd), .io_wr(io_wr), .stall(stall),
      .LoadData(LoadData), .load_valid(load_valid), .fault(fault)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      if (load_valid) begin
         if (sb.size() == 0) chk("ld_unexpected", 32'd1, 32'd0);
         else chk("ld", LoadData, sb.pop_front());
      end

   function automatic logic [3:0] m_we(input logic [2:0] f3, input logic [31:0] ad);
      case (f3[1:0])
         2'b00:   m_we = 4'b0001 << ad[1:0];
         2'b01:   m_we = ad[1] ? 4'b1100 : 4'b0011;
         default: m_we = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] dv);
      case (f3[1:0])
         2'b00:   m_wd = dv << (8 * ad[1:0]);
         2'b01:   m_wd = ad[1] ? dv << 16 : dv;
         default: m_wd = dv;
      endcase
   endfunction

   function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*ad[1:0] +: 8];
      h = w[16*ad[1] +: 16];
      case (f3)
         3'b000:  m_ld = {{24{b[7]}}, b};
         3'b001:  m_ld = {{16{h[15]}}, h};
         3'b100:  m_ld = {24'd0, b};
         3'b101:  m_ld = {16'd0, h};
         default: m_ld = w;
      endcase
   endfunction

   task automatic op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] ad,
                     input logic [31:0] dv, input logic [31:0] rdat, input logic [3:0] exp_we,
                     input logic [31:0] exp_wd, input logic [31:0] exp_ld, input logic drop);
      logic isio;
      isio = ad >= 32'hFFFF_FC00;
      req_valid = 1; MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = ad; ReadData2 = dv;
      #3;
      chk("stall_idle", {31'd0, stall}, 32'd1);
      chk("fault_idle", {31'd0, fault}, 32'd0);
      chk("we_idle", {28'd0, mem_we}, 32'd0);
      @(posedge clk); #1;
      ReadData2 = ~dv;
      if (drop) req_valid = 0;
      mem_rdata = isio ? 32'hAAAA_5555 : rdat;
      io_rdata  = isio ? rdat : 32'h5555_AAAA;
      #3;
      chk("stall_acc", {31'd0, stall}, {31'd0, ~drop});
      chk("we_acc", {28'd0, mem_we}, {28'd0, exp_we});
      chk("io_wr_acc", {31'd0, io_wr}, {31'd0, wr & isio});
      chk("io_rd_acc", {31'd0, io_rd}, {31'd0, rd & isio});
      chk("maddr_acc", {18'd0, mem_addr}, {18'd0, ad[15:2]});
      chk("ioaddr_acc", io_addr, ad);
      chk("lv_acc", {31'd0, load_valid}, 32'd0);
      if (wr) chk("wdata_acc", isio ? io_wdata : mem_wdata, exp_wd);
      if (rd) sb.push_back(exp_ld);
      @(posedge clk); #1;
      #3;
      chk("stall_done", {31'd0, stall}, 32'd0);
      chk("we_done", {28'd0, mem_we}, 32'd0);
      chk("strobe_done", {30'd0, io_rd, io_wr}, 32'd0);
      chk("lv_done", {31'd0, load_valid}, {31'd0, rd});
      req_valid = 0; MemRead = 0; MemWrite = 0;
      @(posedge clk); #1;
      chk("maddr_idle", {18'd0, mem_addr}, 32'd0);
      if (rd) chk("ld_hold", LoadData, exp_ld);
   endtask

   task automatic fop(input string tag, input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] ad);
      req_valid = 1; MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = ad; ReadData2 = 32'hFFFF_FFFF;
      #3;
      chk({tag, "_fault"}, {31'd0, fault}, 32'd1);
      chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      req_valid = 0; MemRead = 0; MemWrite = 0;
      #3;
      chk({tag, "_fault_off"}, {31'd0, fault}, 32'd0);
      chk({tag, "_no_we"}, {28'd0, mem_we, 30'd0} | {31'd0, io_wr}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1; req_valid = 0; MemRead = 0; MemWrite = 0; funct3 = 0;
      ALUResult = 0; ReadData2 = 0; mem_rdata = 0; io_rdata = 0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_ld", LoadData, 32'd0);
      chk("rst_outs", {28'd0, mem_we} | {31'd0, load_valid} | {31'd0, fault} | io_addr, 32'd0);
      rst = 0;
      @(posedge clk); #1;
      op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF, 0, 0);
      op(1, 0, 3'b000, 32'h13, 0, 32'h8000_0000, 0, 0, 32'hFFFF_FF80, 0);
      op(1, 0, 3'b100, 32'h13, 0, 32'h8000_0000, 0, 0, 32'h0000_0080, 0);
      op(0, 1, 3'b001, 32'h22, 32'h1234, 0, 4'b1100, 32'h1234_0000, 0, 0);
      op(0, 1, 3'b000, 32'h31, 32'hAB, 0, 4'b0010, 32'h0000_AB00, 0, 0);
      op(1, 0, 3'b010, 32'h8, 0, 32'h1234_5678, 0, 0, 32'h1234_5678, 0);
      op(1, 0, 3'b001, 32'h2, 0, 32'h8001_0000, 0, 0, 32'hFFFF_8001, 0);
      op(1, 0, 3'b101, 32'h2, 0, 32'h8001_0000, 0, 0, 32'h0000_8001, 0);
      fop("lw_mis", 1, 0, 3'b010, 32'h6);
      fop("rdwr", 1, 1, 3'b010, 32'h10);
      fop("st_f3", 0, 1, 3'b100, 32'h4);
      fop("sh_mis", 0, 1, 3'b001, 32'h21);
      op(0, 1, 3'b010, 32'hFFFF_FC60, 32'h5, 0, 4'b0000, 32'h5, 0, 0);
      op(1, 0, 3'b010, 32'hFFFF_FC70, 0, 32'h7, 0, 0, 32'h7, 0);
      op(1, 0, 3'b000, 32'h31, 0, 32'h0000_7F00, 0, 0, 32'h0000_007F, 1);
      req_valid = 1; MemRead = 0; MemWrite = 1; funct3 = 3'b010; ALUResult = 32'h40; ReadData2 = 32'h11;
      @(posedge clk); #1;
      rst = 1;
      #3;
      chk("rst_acc_we", {28'd0, mem_we}, 32'd0);
      @(posedge clk); #1;
      rst = 0; req_valid = 0; MemWrite = 0;
      #3;
      chk("rst_after_stall", {31'd0, stall}, 32'd0);
      chk("rst_after_we", {28'd0, mem_we}, 32'd0);
      chk("rst_after_ld", LoadData, 32'd0);
      chk("rst_after_addr", {18'd0, mem_addr}, 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 24; i++) begin
         logic        w;
         logic [2:0]  f3;
         logic [31:0] ad, dv, rdat;
         logic [2:0]  rf[5];
         rf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
         w  = $urandom_range(0, 1);
         f3 = w ? 3'($urandom_range(0, 2)) : rf[$urandom_range(0, 4)];
         ad = {18'd0, 14'($urandom)};
         if (f3[1:0] == 2'b01) ad[0] = 0;
         if (f3[1:0] == 2'b10) ad[1:0] = 0;
         dv = $urandom; rdat = $urandom;
         if (w) op(0, 1, f3, ad, dv, 0, m_we(f3, ad), m_wd(f3, ad, dv), 0, 0);
         else op(1, 0, f3, ad, 0, rdat, 0, 0, m_ld(f3, ad, rdat), 0);
      end
      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'hFFFF_FC00; addresses >= IO_BASE route to IO, all others to data RAM.
REQ-002 SHALL have parameter RAM_AW, default 14; word-address width of data RAM.
REQ-003 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  memory instruction present this cycle
- MemRead  in  1  load request
- MemWrite  in  1  store request
- funct3  in  3  access width/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
- ALUResult  in  32  byte address from ALU
- ReadData2  in  32  store data (rs2)
- mem_rdata  in  32  RAM read data, valid one cycle after address
- io_rdata  in  32  IO read data, same timing as mem_rdata
- mem_addr  out  RAM_AW  RAM word address (ALUResult[RAM_AW+1:2] latched)
- mem_wdata  out  32  lane-shifted store data
- mem_we  out  4  RAM byte write enables
- io_addr  out  32  latched byte address for IO
- io_wdata  out  32  lane-shifted store data for IO
- io_rd  out  1  IO read strobe
- io_wr  out  1  IO write strobe
- stall  out  1  hold PC/pipeline
- LoadData  out  32  extended load result
- load_valid  out  1  LoadData valid this cycle
- fault  out  1  misaligned/illegal access pulse

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-005 SHALL accept a request in IDLE when req_valid & (MemRead ^ MemWrite) & legal funct3 & aligned address; latch address, store data, funct3, direction, IO select; go ACCESS.
REQ-006 SHALL treat as faulting: halfword with addr[0]=1, word with addr[1:0]!=0, funct3 not listed for the direction (stores: 000/001/010 only), or MemRead & MemWrite both 1.
REQ-007 On fault in IDLE: fault=1 for exactly that cycle, no strobe or we, state stays IDLE, stall=0.
REQ-008 stall SHALL equal req_valid & (MemRead | MemWrite) & ~fault_cond while state is IDLE or ACCESS, and 0 in DONE; combinational.
REQ-009 ACCESS: RAM store drives mem_we for exactly one cycle (sb 0001<<addr[1:0], sh 0011<<{addr[1],1'b0}, sw 1111); IO store asserts io_wr one cycle; loads assert io_rd one cycle if IO, else nothing extra; next state DONE.
REQ-010 mem_wdata/io_wdata SHALL be store data shifted left by 8*addr[1:0] (byte) or 16*addr[1] (half); unchanged for word.
REQ-011 mem_addr and io_addr SHALL be driven from latched address in ACCESS and DONE; 0 in IDLE.
REQ-012 DONE, load: select mem_rdata or io_rdata, extract lane by latched addr[1:0], sign-extend (b/h) or zero-extend (bu/hu); LoadData valid combinationally, load_valid=1 one cycle; registered copy held in LoadData until next load completes.
REQ-013 DONE always returns to IDLE; a request is never accepted in DONE, so back-to-back accesses cost 2 stall cycles each (load/store latency 3 cycles IDLE->ACCESS->DONE).
REQ-014 req_valid dropping during ACCESS SHALL NOT abort the access.
REQ-015 mem_we, io_rd, io_wr SHALL never assert outside ACCESS.

Reset
REQ-016 rst=1 at a clock edge SHALL force IDLE, clear latches, LoadData=0, and all outputs to 0 that cycle onward, including mid-ACCESS (pending store suppressed if rst coincides with ACCESS edge after reset).
REQ-017 After rst deasserts, first request SHALL be accepted in the following IDLE cycle.

Verification
REQ-018 sw ALUResult=0x0000_0010, ReadData2=0xDEADBEEF -> ACCESS: mem_addr=4, mem_we=1111, mem_wdata=0xDEADBEEF; stall 1,1,0 over 3 cycles.
REQ-019 lb addr 0x13, mem_rdata=0x80_00_00_00 -> DONE: LoadData=0xFFFFFF80, load_valid=1; lbu same -> 0x0000_0080.
REQ-020 sh addr 0x22, ReadData2=0x0000_1234 -> mem_we=1100, mem_wdata=0x1234_0000.
REQ-021 lw addr 0x6 -> fault=1 one cycle, stall=0, no mem_we; MemRead&MemWrite=1 -> fault=1.
REQ-022 sw addr 0xFFFF_FC60, data 0x5 -> io_wr=1 in ACCESS, io_addr=0xFFFF_FC60, mem_we=0000; lw 0xFFFF_FC70, io_rdata=0x7 -> LoadData=0x7.
REQ-023 rst asserted in ACCESS of an sw -> next cycle IDLE, mem_we=0, stall=0, LoadData=0.
